cpu_trace_emitter: RTL and testbench
====================================

// Module: cpu_trace_emitter
// PURPOSE
//  On-chip counterpart of the bench per-cycle state dump. Samples CPU state
//  every cycle while the CPU runs: cycle index, PC, stall count and flush count.
//  Buffers each snapshot as a 4-word record and streams it out on a 32-bit
//  valid/ready port to an external sink (host link or logger).
//  Sits beside CPU; taps PC.pc_o, HD.stall_o, HD.flush_o, Control.jump_o and Control.branch_o.
// PARAMETERS
//  DEPTH       4    record FIFO depth (records, power of 2, >=2)
//  MAX_CYCLES  70   snapshots taken for cycle index 0..MAX_CYCLES-1, then stop
//  CNT_W       32   width of cycle/stall/flush counters (<=32, zero-extended)
// PORTS
//  clk_i          in   1   clock
//  rst_n_i        in   1   async active-low reset
//  start_i        in   1   CPU start; snapshots only while high
//  pc_i           in   32  current PC (PC.pc_o)
//  stall_i        in   1   hazard stall (HD.stall_o)
//  flush_i        in   2   hazard flush code (HD.flush_o)
//  jump_i         in   1   Control.jump_o
//  branch_i       in   1   Control.branch_o
//  trace_valid_o  out  1   trace word valid
//  trace_ready_i  in   1   sink accepts word
//  trace_data_o   out  32  trace word
//  trace_last_o   out  1   last word of record (W3)
//  overflow_o     out  1   sticky: at least one record dropped
//  drop_cnt_o     out  16  dropped-record count, saturating at 16'hFFFF
//  done_o         out  1   capture finished and all records drained
// BEHAVIOUR
//  - Reset (async, rst_n_i low): all counters, FIFO pointers and serializer are cleared.
//    All outputs are 0 immediately. A partial record is abandoned; nothing resumes after release.
//  - Events per posedge with start_i=1: stall_evt = stall_i & ~jump_i & ~branch_i;
//    flush_evt = (flush_i==2'b01). The stall and flush counters add the event; counters wrap at CNT_W.
//  - Snapshot at a posedge when start_i=1 and cyc < MAX_CYCLES. The record uses cyc before
//    its increment and stall/flush counts after they add this edge's events.
//    cyc then increments by 1. Nothing is counted or captured while start_i=0.
//  - Record: W0={8'hC5,7'b0,ovf_pend,cyc[15:0]}; W1=pc_i; W2=stall count; W3=flush count.
//    ovf_pend=1 if any drop happened since the previous pushed record. It clears on push.
//  - FIFO full at snapshot: the record is dropped, overflow_o is set (sticky), drop_cnt_o
//    increments (saturating) and ovf_pend is set. Exception: if W3 completes a handshake on the
//    same edge, the slot frees and the push succeeds (no drop).
//  - Serializer states: IDLE, W0, W1, W2, W3. IDLE->W0 when the FIFO is non-empty. Wn->Wn+1 on
//    valid&ready. W3 pops the FIFO on handshake, then goes to W0 if entries remain, else IDLE.
//  - trace_valid_o=1 in W0..W3. Data and last stay stable while valid & ~ready. Valid is never
//    withdrawn without a handshake, except on reset. trace_last_o=1 only in W3.
//  - Latency: with the FIFO empty, a snapshot at edge N gives trace_valid_o=1 with W0 after edge N+1.
//    Back-to-back records with ready held high: 4 words in 4 cycles, no idle gap.
//  - done_o rises the cycle after cyc reaches MAX_CYCLES, the FIFO is empty and the state is IDLE.
//    It then holds until reset.
//  - start_i dropping mid-record: capture pauses; the serializer still drains the FIFO.
// TESTING
//  T1 reset: rst_n_i low mid-W1 -> valid/last/data/overflow/drop/done all 0 in the same cycle;
//     after release the first word out is W0 of a new record with cyc=0.
//  T2 basic: ready=1, pc_i=0,4,8..., no events -> records (cyc n, pc 4n, 0, 0);
//     first W0=32'hC5000000 one cycle after the first capture edge.
//  T3 counting: stall_i=1 with branch_i=1 on cycle 3, stall_i=1 alone on cycle 5,
//     flush_i=2'b10 then 2'b01 -> record cyc=5 has W2=1; flush counts only 01.
//  T4 backpressure: ready=0 for 20 cycles, DEPTH=4 -> 4 records buffered, 16 dropped,
//     drop_cnt_o=16, overflow_o=1; the first record pushed afterwards has W0 bit16=1.
//  T5 full+pop same edge: FIFO full and W3 accepted on the capture edge -> no drop, drop_cnt_o unchanged.
//  T6 completion: MAX_CYCLES=70, ready=1 -> exactly 70 records (280 words, 70 last pulses),
//     done_o=1 after the final W3, no further valid.

Source files
------------

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter: samples CPU cycle/PC/stall/flush state each running
// cycle into 4-word records, buffers them and streams them on a 32-bit
// valid/ready port.
// Ports: clk_i, rst_n_i (async low); start_i, pc_i, stall_i, flush_i,
//   jump_i, branch_i (CPU taps); trace_valid_o/ready_i/data_o/last_o (sink);
//   overflow_o, drop_cnt_o, done_o (status).
module cpu_trace_emitter #(
  parameter int DEPTH      = 4,
  parameter int MAX_CYCLES = 70,
  parameter int CNT_W      = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic [1:0]  flush_i,
  input  logic        jump_i,
  input  logic        branch_i,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o,
  output logic        done_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_W1,
    S_W2,
    S_W3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;
  logic [CNT_W-1:0] w_stall_nxt;
  logic [CNT_W-1:0] w_flush_nxt;

  logic w_stall_evt;
  logic w_flush_evt;
  logic w_snap;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_full;
  logic w_empty;

  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_nxt;

  logic [3:0][31:0] r_mem [DEPTH];
  logic [3:0][31:0] w_rec;
  logic [3:0][31:0] w_head;

  logic        r_ovf_pend;
  logic        r_overflow;
  logic [15:0] r_drop_cnt;
  logic        r_done;

  assign w_stall_evt = start_i & stall_i & ~jump_i & ~branch_i;
  assign w_flush_evt = start_i & (flush_i == 2'b01);
  assign w_stall_nxt = r_stall + CNT_W'(w_stall_evt);
  assign w_flush_nxt = r_flush + CNT_W'(w_flush_evt);

  assign w_snap  = start_i & (r_cyc < CNT_W'(MAX_CYCLES));
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = (r_state == S_W3) & trace_ready_i;
  // A W3 handshake on the capture edge frees the slot for this push.
  assign w_push  = w_snap & (~w_full | w_pop);
  assign w_drop  = w_snap & ~w_push;

  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign w_rec[0] = {8'hC5, 7'b0, r_ovf_pend, 16'(r_cyc)};
  assign w_rec[1] = pc_i;
  assign w_rec[2] = 32'(w_stall_nxt);
  assign w_rec[3] = 32'(w_flush_nxt);

  assign w_head = r_mem[r_rd];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cyc   <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_stall <= w_stall_nxt;
      r_flush <= w_flush_nxt;
      if (w_snap) r_cyc <= r_cyc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= w_rec;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf_pend <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push)      r_ovf_pend <= 1'b0;
      else if (w_drop) r_ovf_pend <= 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF)
          r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_done <= 1'b0;
    end else if (r_cyc >= CNT_W'(MAX_CYCLES) && w_empty
                 && r_state == S_IDLE) begin
      r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (!w_empty)     w_state_nxt = S_W0;
      S_W0:   if (trace_ready_i) w_state_nxt = S_W1;
      S_W1:   if (trace_ready_i) w_state_nxt = S_W2;
      S_W2:   if (trace_ready_i) w_state_nxt = S_W3;
      S_W3: begin
        if (trace_ready_i)
          w_state_nxt = (w_cnt_nxt != '0) ? S_W0 : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    trace_data_o = '0;
    unique case (r_state)
      S_W0:    trace_data_o = w_head[0];
      S_W1:    trace_data_o = w_head[1];
      S_W2:    trace_data_o = w_head[2];
      S_W3:    trace_data_o = w_head[3];
      default: trace_data_o = '0;
    endcase
  end

  assign trace_valid_o = (r_state != S_IDLE);
  assign trace_last_o  = (r_state == S_W3);
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;
  assign done_o        = r_done;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb_cpu_trace_emitter: directed stimulus with a word scoreboard;
// a negedge monitor pops expected words on each accepted beat.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        stall;
  logic [1:0]  flush;
  logic        jump;
  logic        branch;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;
  logic        ovf;
  logic [15:0] drops;
  logic        done;

  cpu_trace_emitter dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .pc_i         (pc),
    .stall_i      (stall),
    .flush_i      (flush),
    .jump_i       (jump),
    .branch_i     (branch),
    .trace_valid_o(valid),
    .trace_ready_i(ready),
    .trace_data_o (data),
    .trace_last_o (last),
    .overflow_o   (ovf),
    .drop_cnt_o   (drops),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } wd_t;

  wd_t q[$];
  wd_t mon_e;
  int  tests   = 0;
  int  errors  = 0;
  int  n_words = 0;
  int  n_last  = 0;
  int  cyc_m   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_rec(input int c, input logic o,
                          input logic [31:0] p,
                          input logic [31:0] s,
                          input logic [31:0] f);
    wd_t w;
    w.d = {8'hC5, 7'b0, o, c[15:0]};
    w.l = 1'b0;
    q.push_back(w);
    w.d = p;
    q.push_back(w);
    w.d = s;
    q.push_back(w);
    w.d = f;
    w.l = 1'b1;
    q.push_back(w);
  endtask

  // One capture edge followed by three idle cycles.
  task automatic snap(input logic [31:0] p,
                      input logic s, input logic j,
                      input logic b, input logic [1:0] f,
                      input logic o,
                      input logic [31:0] es,
                      input logic [31:0] ef);
    pc = p;
    stall = s;
    jump = j;
    branch = b;
    flush = f;
    start = 1'b1;
    push_rec(cyc_m, o, p, es, ef);
    cyc_m++;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    start = 1'b0;
    q.delete();
    n_words = 0;
    n_last = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc_m = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      n_words++;
      if (last) n_last++;
      if (q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL extra_word: got %h expected none", data);
      end else begin
        mon_e = q.pop_front();
        chk("word", data, mon_e.d);
        chk("last", 32'(last), 32'(mon_e.l));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pc = '0;
    stall = 1'b0;
    flush = 2'b00;
    jump = 1'b0;
    branch = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_drops", 32'(drops), 0);
    rst_n = 1'b1;

    // Basic stream, event counting and completion.
    start = 1'b1;
    push_rec(0, 1'b0, 32'h0, 0, 0);
    cyc_m = 1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("lat_not_yet", 32'(valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(valid), 1);
    chk("lat_w0", data, 32'hC500_0000);
    repeat (2) @(posedge clk);
    #1;
    for (int n = 1; n < 70; n++) begin
      case (n)
        3: snap(32'(4*n), 1, 0, 1, 2'b00, 0, 0, 0);
        5: snap(32'(4*n), 1, 0, 0, 2'b00, 0, 1, 0);
        6: snap(32'(4*n), 0, 0, 0, 2'b10, 0, 1, 0);
        7: snap(32'(4*n), 0, 0, 0, 2'b01, 0, 1, 1);
        8: snap(32'(4*n), 1, 1, 0, 2'b11, 0, 1, 1);
        default: snap(32'(4*n), 0, 0, 0, 2'b00, 0,
                      (n < 5) ? 0 : 1, (n < 7) ? 0 : 1);
      endcase
    end
    chk("done_early", 32'(done), 0);
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("done_set", 32'(done), 1);
    chk("done_q", 32'(q.size()), 0);
    chk("n_words", 32'(n_words), 280);
    chk("n_last", 32'(n_last), 70);
    repeat (10) @(posedge clk);
    #1;
    chk("done_quiet", 32'(valid), 0);
    chk("done_hold", 32'(done), 1);

    // Backpressure: 4 buffered, 16 dropped.
    do_reset();
    ready = 1'b0;
    stall = 1'b0;
    flush = 2'b00;
    jump = 1'b0;
    branch = 1'b0;
    pc = 32'h40;
    start = 1'b1;
    for (int k = 0; k < 4; k++)
      push_rec(k, 1'b0, 32'h40, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid", 32'(valid), 1);
    chk("bp_data", data, 32'hC500_0000);
    chk("bp_last", 32'(last), 0);
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    chk("bp_drops", 32'(drops), 16);
    chk("bp_ovf", 32'(ovf), 1);
    cyc_m = 20;
    ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_drained", 32'(q.size()), 0);
    snap(32'h44, 0, 0, 0, 2'b00, 1, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_q", 32'(q.size()), 0);
    chk("bp_sticky", 32'(ovf), 1);

    // Full FIFO with W3 accepted on the capture edge.
    do_reset();
    ready = 1'b0;
    pc = 32'h100;
    start = 1'b1;
    for (int k = 0; k < 4; k++)
      push_rec(k, 1'b0, 32'h100, 0, 0);
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fp_in_w3", 32'(last), 1);
    pc = 32'h200;
    start = 1'b1;
    push_rec(4, 1'b0, 32'h200, 0, 0);
    cyc_m = 5;
    @(posedge clk);
    #1 start = 1'b0;
    chk("fp_drops", 32'(drops), 0);
    chk("fp_ovf", 32'(ovf), 0);
    repeat (25) @(posedge clk);
    #1;
    chk("fp_q", 32'(q.size()), 0);

    // Reset in the middle of W1.
    do_reset();
    ready = 1'b1;
    pc = 32'h80;
    start = 1'b1;
    push_rec(0, 1'b0, 32'h80, 0, 0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_w1", data, 32'h80);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(valid), 0);
    chk("mr_last", 32'(last), 0);
    chk("mr_data", data, 0);
    chk("mr_ovf", 32'(ovf), 0);
    chk("mr_drops", 32'(drops), 0);
    chk("mr_done", 32'(done), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc_m = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_idle", 32'(valid), 0);
    snap(32'h84, 0, 0, 0, 2'b00, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("mr_q", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
